// File: rtl/fifo.sv
// Purpose: single-clock FIFO buffering FIFO_WIDTH-bit words from a producer (_a) to a consumer (_b).
// Latency: a written word is readable the next cycle; read data appears one cycle after an accepted read.
// Backpressure: writes are dropped while full and reads are ignored while empty; no error is flagged.
//
// Ports:
//   clk     - single clock; all state changes on the rising edge
//   rst_n   - asynchronous active-low reset (clears pointers, count and dout_b; mem untouched)
//   din_a   - write data
//   wen_a   - write request, accepted when !full
//   ren_b   - read request, accepted when !empty
//   dout_b  - registered read data, holds when no read is accepted
//   full    - FIFO holds FIFO_DEPTH words
//   empty   - FIFO holds no words
module fifo #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FIFO_WIDTH-1:0] din_a,
    input  logic                  wen_a,
    input  logic                  ren_b,
    output logic [FIFO_WIDTH-1:0] dout_b,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    // Storage carries no reset so it maps onto plain RAM.
    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [AW-1:0]         wptr_q,  wptr_d;
    logic [AW-1:0]         rptr_q,  rptr_d;
    logic [AW:0]           count_q, count_d;
    logic [FIFO_WIDTH-1:0] dout_q,  dout_d;

    logic wr_acc;
    logic rd_acc;

    // Flags decode the registered count only, so they never anticipate an edge.
    assign full   = (count_q == DEPTH_C);
    assign empty  = (count_q == '0);
    assign dout_b = dout_q;

    // The rst_n term keeps mem from being written while reset is held,
    // since full is low during reset and would otherwise let writes through.
    assign wr_acc = wen_a && !full && rst_n;
    assign rd_acc = ren_b && !empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        dout_d  = dout_q;

        // Pointers are exactly AW bits, so +1 wraps from DEPTH-1 to 0.
        if (wr_acc) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (rd_acc) begin
            rptr_d = rptr_q + 1'b1;
            dout_d = mem[rptr_q];
        end

        // A simultaneous accepted read and write leaves occupancy unchanged.
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr_q] <= din_a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
        end
    end

endmodule

// File: tb/tb_fifo.sv
// Purpose: self-checking bench for fifo (16 x 512) using vector tables, directed corners and a queue scoreboard.
// Latency: stimulus is driven on the falling edge and outputs are sampled on the following falling edge.
// Backpressure: the scoreboard only accepts writes when its own count is below depth and reads when non-empty.
module tb_fifo;

    localparam int W = 16;
    localparam int D = 512;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] din_a;
    logic         wen_a;
    logic         ren_b;
    logic [W-1:0] dout_b;
    logic         full;
    logic         empty;

    int total;
    int bad;

    logic [W-1:0] sb_q[$];
    logic [W-1:0] m_dout;

    typedef struct {
        logic         w;
        logic         r;
        logic [W-1:0] d;
        logic [W-1:0] e_dout;
        logic         e_full;
        logic         e_empty;
    } vec_t;

    vec_t vecs[12];

    fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .din_a  (din_a),
        .wen_a  (wen_a),
        .ren_b  (ren_b),
        .dout_b (dout_b),
        .full   (full),
        .empty  (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock of traffic: update the scoreboard from its own occupancy,
    // then compare dout_b/full/empty after the edge.
    task automatic cycle(input logic w, input logic r, input logic [W-1:0] d);
        bit wa;
        bit ra;
        wa = w && (sb_q.size() < D);
        ra = r && (sb_q.size() > 0);
        wen_a = w;
        ren_b = r;
        din_a = d;
        @(posedge clk);
        if (ra) m_dout = sb_q.pop_front();
        if (wa) sb_q.push_back(d);
        @(negedge clk);
        check("dout", 32'(dout_b), 32'(m_dout));
        check("full", 32'(full), 32'(sb_q.size() == D));
        check("empty", 32'(empty), 32'(sb_q.size() == 0));
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        m_dout = '0;

        // Ordered write/read, then underflow holding 00AA.
        vecs[0]  = '{1'b1, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 16'h0000, 16'h0001, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 16'h0000, 16'h0002, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 16'h0000, 16'h0003, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 16'h0000, 16'h0003, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 16'h00AA, 16'h0003, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 16'h0000, 16'h00AA, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 16'h0000, 16'h00AA, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 16'h0000, 16'h00AA, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 16'h0055, 16'h00AA, 1'b0, 1'b0};

        // Reset held with both requests active.
        rst_n = 1'b0;
        wen_a = 1'b1;
        ren_b = 1'b1;
        din_a = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            din_a = 16'($urandom);
            @(negedge clk);
            check("rst_dout", 32'(dout_b), 32'h0);
            check("rst_empty", 32'(empty), 32'h1);
            check("rst_full", 32'(full), 32'h0);
        end
        wen_a = 1'b0;
        ren_b = 1'b0;
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 16'h0);
        check("post_rst_count", 32'(dut.count_q), 32'h0);

        // Table-driven vectors.
        for (int i = 0; i < 12; i++) begin
            cycle(vecs[i].w, vecs[i].r, vecs[i].d);
            check($sformatf("vec%0d_dout", i), 32'(dout_b), 32'(vecs[i].e_dout));
            check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].e_full));
            check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].e_empty));
        end
        // Pointers survived the underflow: the 0055 written last comes out next.
        cycle(1'b0, 1'b1, 16'h0);
        check("after_underflow", 32'(dout_b), 32'h0055);

        // Fill to full with value i.
        for (int i = 0; i < D; i++) cycle(1'b1, 1'b0, 16'(i));
        check("fill_full", 32'(full), 32'h1);
        cycle(1'b1, 1'b0, 16'hFFFF);
        check("overflow_count", 32'(dut.count_q), 32'(D));

        // Full with both requests: oldest out, write rejected.
        cycle(1'b1, 1'b1, 16'hBEEF);
        check("full_rw_dout", 32'(dout_b), 32'h0);
        check("full_rw_full", 32'(full), 32'h0);
        check("full_rw_count", 32'(dut.count_q), 32'(D - 1));

        // Drain the rest; scoreboard catches any stray FFFF/BEEF.
        for (int i = 1; i < D; i++) cycle(1'b0, 1'b1, 16'h0);
        check("drain_last", 32'(dout_b), 32'h01FF);
        check("drain_empty", 32'(empty), 32'h1);

        // Empty with both requests: write accepted, dout_b holds.
        cycle(1'b1, 1'b1, 16'h1234);
        check("empty_rw_empty", 32'(empty), 32'h0);
        check("empty_rw_dout", 32'(dout_b), 32'h01FF);
        cycle(1'b0, 1'b1, 16'h0);
        check("empty_rw_read", 32'(dout_b), 32'h1234);

        // Mid-operation asynchronous reset.
        cycle(1'b1, 1'b0, 16'h0A0A);
        cycle(1'b1, 1'b0, 16'h0B0B);
        wen_a = 1'b0;
        ren_b = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_dout", 32'(dout_b), 32'h0);
        check("async_rst_empty", 32'(empty), 32'h1);
        check("async_rst_count", 32'(dut.count_q), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
        m_dout = '0;
        // First write accepted on the first edge after release.
        cycle(1'b1, 1'b0, 16'h7777);
        check("post_rst_write", 32'(empty), 32'h0);
        cycle(1'b0, 1'b1, 16'h0);
        check("post_rst_read", 32'(dout_b), 32'h7777);

        // Random soak: write-heavy then read-heavy phases force full, empty and wrap.
        for (int i = 0; i < 2000; i++) begin
            int pw;
            pw = ((i / 1000) % 2 == 0) ? 85 : 15;
            cycle($urandom_range(0, 99) < pw, $urandom_range(0, 99) < (100 - pw), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
